note_detector: RTL and testbench

Receive-side counterpart of the per-note square-wave generators: measures the period of an incoming square wave (tone_in), classifies it as one of the 12 chromatic notes C4..B4, and reports the note index once the tone is stable. Sits between the external tone source (or a generator's ClkRedu pin) and the display/scoring logic of the piano design.

---
 rtl/note_pkg.sv | 107 ++++++++++
 rtl/note_classifier.sv | 37 +++
 rtl/note_detector.sv | 178 +++++++++++++++++
 tb/tb_note_detector.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// note_pkg - shared constants and types for the receive-side note logic.
//   * note frequencies (centi-hertz) for the 12 chromatic notes C4..B4
//   * helper functions deriving nominal periods and band limits from a clock rate
//   * nominal periods P_0..P_11 and band limit tables for the default clock
//   * FSM state enum and the 4-bit note index type
package note_pkg;

    localparam int unsigned DEF_CLK_HZ = 50_000_000;
    localparam int          NUM_NOTES  = 12;
    localparam int          PERIOD_W   = 20;

    typedef logic [3:0]          note_idx_t;
    typedef logic [PERIOD_W-1:0] period_t;

    typedef enum logic [1:0] {
        ST_SILENT = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCK   = 2'd2
    } det_state_t;

    // Note frequencies in units of 0.01 Hz, index 0 = C4 .. 11 = B4.
    function automatic int unsigned note_freq_chz(input int i);
        case (i)
            0:       return 26163;
            1:       return 27718;
            2:       return 29366;
            3:       return 31113;
            4:       return 32963;
            5:       return 34923;
            6:       return 36999;
            7:       return 39200;
            8:       return 41530;
            9:       return 44000;
            10:      return 46616;
            default: return 49388;
        endcase
    endfunction

    // Nominal period in clock cycles, rounded to nearest.
    function automatic int unsigned note_period(input int unsigned clk_hz, input int i);
        longint unsigned f;
        longint unsigned num;
        f   = 64'(note_freq_chz(i));
        num = 64'(clk_hz) * 64'd100 + f / 64'd2;
        return 32'(num / f);
    endfunction

    // Lowest period belonging to note i. The midpoint towards the higher note
    // (shorter period) is inclusive, so a period exactly on a midpoint goes to
    // the lower note index.
    function automatic int unsigned band_lo(input int unsigned clk_hz, input int i);
        int unsigned p_long;
        int unsigned p_short;
        if (i == NUM_NOTES - 1) begin
            p_long  = note_period(clk_hz, i - 1);
            p_short = note_period(clk_hz, i);
            return p_short - (p_long - p_short) / 2;
        end
        p_long  = note_period(clk_hz, i);
        p_short = note_period(clk_hz, i + 1);
        return p_short + (p_long - p_short) / 2;
    endfunction

    // Highest period belonging to note i: one below the next-lower note's floor.
    function automatic int unsigned band_hi(input int unsigned clk_hz, input int i);
        int unsigned p0;
        int unsigned p1;
        if (i == 0) begin
            p0 = note_period(clk_hz, 0);
            p1 = note_period(clk_hz, 1);
            return p0 + (p0 - p1) / 2;
        end
        return band_lo(clk_hz, i - 1) - 1;
    endfunction

    localparam period_t P_0  = period_t'(note_period(DEF_CLK_HZ, 0));
    localparam period_t P_1  = period_t'(note_period(DEF_CLK_HZ, 1));
    localparam period_t P_2  = period_t'(note_period(DEF_CLK_HZ, 2));
    localparam period_t P_3  = period_t'(note_period(DEF_CLK_HZ, 3));
    localparam period_t P_4  = period_t'(note_period(DEF_CLK_HZ, 4));
    localparam period_t P_5  = period_t'(note_period(DEF_CLK_HZ, 5));
    localparam period_t P_6  = period_t'(note_period(DEF_CLK_HZ, 6));
    localparam period_t P_7  = period_t'(note_period(DEF_CLK_HZ, 7));
    localparam period_t P_8  = period_t'(note_period(DEF_CLK_HZ, 8));
    localparam period_t P_9  = period_t'(note_period(DEF_CLK_HZ, 9));
    localparam period_t P_10 = period_t'(note_period(DEF_CLK_HZ, 10));
    localparam period_t P_11 = period_t'(note_period(DEF_CLK_HZ, 11));

    localparam period_t BAND_LO [NUM_NOTES] = '{
        period_t'(band_lo(DEF_CLK_HZ, 0)), period_t'(band_lo(DEF_CLK_HZ, 1)),
        period_t'(band_lo(DEF_CLK_HZ, 2)), period_t'(band_lo(DEF_CLK_HZ, 3)),
        period_t'(band_lo(DEF_CLK_HZ, 4)), period_t'(band_lo(DEF_CLK_HZ, 5)),
        period_t'(band_lo(DEF_CLK_HZ, 6)), period_t'(band_lo(DEF_CLK_HZ, 7)),
        period_t'(band_lo(DEF_CLK_HZ, 8)), period_t'(band_lo(DEF_CLK_HZ, 9)),
        period_t'(band_lo(DEF_CLK_HZ, 10)), period_t'(band_lo(DEF_CLK_HZ, 11))
    };

    localparam period_t BAND_HI [NUM_NOTES] = '{
        period_t'(band_hi(DEF_CLK_HZ, 0)), period_t'(band_hi(DEF_CLK_HZ, 1)),
        period_t'(band_hi(DEF_CLK_HZ, 2)), period_t'(band_hi(DEF_CLK_HZ, 3)),
        period_t'(band_hi(DEF_CLK_HZ, 4)), period_t'(band_hi(DEF_CLK_HZ, 5)),
        period_t'(band_hi(DEF_CLK_HZ, 6)), period_t'(band_hi(DEF_CLK_HZ, 7)),
        period_t'(band_hi(DEF_CLK_HZ, 8)), period_t'(band_hi(DEF_CLK_HZ, 9)),
        period_t'(band_hi(DEF_CLK_HZ, 10)), period_t'(band_hi(DEF_CLK_HZ, 11))
    };

endpackage

// File: rtl/note_classifier.sv
// note_classifier - combinational period-to-note lookup.
// Ports:
//   meas  in  20  measured period in clock cycles
//   match out 1   meas falls inside one of the 12 note bands
//   idx   out 4   note index (0=C4 .. 11=B4), 0 when no match
// Parameter CLK_HZ sets the clock rate the band limits are derived from.
module note_classifier
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
    input  logic [19:0] meas,
    output logic        match,
    output logic [3:0]  idx
);

    logic [NUM_NOTES-1:0] hit;

    for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_band
        localparam period_t LO = period_t'(band_lo(CLK_HZ, gi));
        localparam period_t HI = period_t'(band_hi(CLK_HZ, gi));
        assign hit[gi] = (meas >= LO) && (meas <= HI);
    end

    // Bands are disjoint; scanning downwards leaves the lowest hit index.
    always_comb begin
        match = 1'b0;
        idx   = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match = 1'b1;
                idx   = note_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/note_detector.sv
// note_detector - measures the period of an incoming square wave, classifies
// it as one of the chromatic notes C4..B4 and reports the note once stable.
// Ports:
//   clk         in  1   system clock
//   reset       in  1   asynchronous, active-high reset
//   tone_in     in  1   asynchronous square-wave input
//   note_idx    out 4   locked note, 0=C4 .. 11=B4
//   note_valid  out 1   high while locked
//   note_strobe out 1   one-cycle pulse on each entry to lock
//   period_out  out 20  last measured period (only with NOTE_DET_PERIOD_OUT_EN)
// Optional feature macro: NOTE_DET_PERIOD_OUT_EN.
module note_detector
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
    parameter int unsigned STABLE_COUNT = 3,
    parameter int unsigned TIMEOUT_CYC  = 400_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tone_in,
    output logic [3:0]  note_idx,
    output logic        note_valid,
    output logic        note_strobe
`ifdef NOTE_DET_PERIOD_OUT_EN
    ,
    output logic [19:0] period_out
`endif
);

    localparam period_t   CNT_MAX     = '1;
    localparam period_t   CNT_ONE     = period_t'(1);
    localparam period_t   TIMEOUT_LIM = period_t'(TIMEOUT_CYC);
    localparam logic [3:0] STABLE_LIM = 4'(STABLE_COUNT);

    // Input synchronizer, edge register and registered rising-edge pulse.
    logic sync1_q, sync2_q, sync3_q, edge_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= tone_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
        end
    end

    // Period counter: restarts at 1 on each edge so that the value seen at
    // the next edge is exactly the number of cycles between the two edges.
    period_t cnt_q, cnt_d;

    always_comb begin
        if (edge_q)
            cnt_d = CNT_ONE;
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    logic timeout;
    assign timeout = (cnt_q >= TIMEOUT_LIM);

    // The counter value at the edge is the period being captured, so it is
    // classified directly rather than waiting a cycle for a meas register.
    logic      cls_match;
    note_idx_t cls_idx;

    note_classifier #(
        .CLK_HZ (CLK_HZ)
    ) u_classifier (
        .meas  (cnt_q),
        .match (cls_match),
        .idx   (cls_idx)
    );

    det_state_t state_q;
    note_idx_t  cand_q, note_idx_q;
    logic [3:0] stable_q;
    logic       valid_q, strobe_q;

    // Candidate/stability update shared by ACQ and by a mismatch in LOCK.
    note_idx_t  acq_cand_d;
    logic [3:0] acq_stable_d;

    always_comb begin
        acq_cand_d   = cand_q;
        acq_stable_d = '0;
        if (cls_match) begin
            if (cls_idx == cand_q) begin
                acq_stable_d = stable_q + 4'd1;
            end else begin
                acq_cand_d   = cls_idx;
                acq_stable_d = 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SILENT;
            cand_q     <= '0;
            stable_q   <= '0;
            note_idx_q <= '0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            // Timeout takes priority over a coincident edge.
            if (timeout) begin
                state_q  <= ST_SILENT;
                valid_q  <= 1'b0;
                stable_q <= '0;
            end else if (edge_q) begin
                case (state_q)
                    ST_SILENT: begin
                        // First edge only starts the period measurement.
                        state_q  <= ST_ACQ;
                        stable_q <= '0;
                    end
                    ST_ACQ: begin
                        cand_q   <= acq_cand_d;
                        stable_q <= acq_stable_d;
                        if (cls_match && acq_stable_d == STABLE_LIM) begin
                            state_q    <= ST_LOCK;
                            note_idx_q <= acq_cand_d;
                            valid_q    <= 1'b1;
                            strobe_q   <= 1'b1;
                        end
                    end
                    ST_LOCK: begin
                        if (!(cls_match && cls_idx == note_idx_q)) begin
                            state_q  <= ST_ACQ;
                            valid_q  <= 1'b0;
                            cand_q   <= acq_cand_d;
                            stable_q <= acq_stable_d;
                        end
                    end
                    default: begin
                        state_q  <= ST_SILENT;
                        valid_q  <= 1'b0;
                        stable_q <= '0;
                    end
                endcase
            end
        end
    end

    assign note_idx    = note_idx_q;
    assign note_valid  = valid_q;
    assign note_strobe = strobe_q;

`ifdef NOTE_DET_PERIOD_OUT_EN
    period_t period_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            period_q <= '0;
        else if (edge_q)
            period_q <= cnt_q;
    end

    assign period_out = period_q;
`endif

endmodule

// File: tb/tb_note_detector.sv
`timescale 1ns/1ps
// Directed bench for note_detector. The detector runs with a 50 kHz clock
// setting (1/1000 of the default), so every note period shrinks by 1000 and
// the timeout is 400 cycles. Nominal periods at this rate:
//   C4 191, C#4 180, D4 170, D#4 161, E4 152, F4 143, F#4 135, G4 128,
//   G#4 120, A4 114, A#4 107, B4 101.
// Band edges used below: C4 = [185,196], C#4 = [175,184], B4 = [98,103].
module tb_note_detector;

    localparam int unsigned TB_CLK_HZ  = 50_000;
    localparam int unsigned TB_STABLE  = 3;
    localparam int unsigned TB_TIMEOUT = 400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tone_in = 1'b0;
    logic [3:0]  note_idx;
    logic        note_valid;
    logic        note_strobe;
`ifdef NOTE_DET_PERIOD_OUT_EN
    logic [19:0] period_out;
`endif

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int s0;

    note_detector #(
        .CLK_HZ       (TB_CLK_HZ),
        .STABLE_COUNT (TB_STABLE),
        .TIMEOUT_CYC  (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tone_in     (tone_in),
        .note_idx    (note_idx),
        .note_valid  (note_valid),
        .note_strobe (note_strobe)
`ifdef NOTE_DET_PERIOD_OUT_EN
        ,
        .period_out  (period_out)
`endif
    );

    always #5 clk = ~clk;

    // Counts cycles with note_strobe high, so a stuck strobe counts more than once.
    always @(posedge clk) begin
        if (note_strobe === 1'b1)
            strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("[%0t] check %s: observed %0d expected %0d", $time, tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One full period starting with a rising edge.
    task automatic drive_period(input int p);
        tone_in = 1'b1;
        tick(p / 2);
        tone_in = 1'b0;
        tick(p - p / 2);
    endtask

    task automatic drive_n(input int p, input int n);
        for (int k = 0; k < n; k++)
            drive_period(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    int bnd_p   [6] = '{185, 184, 196, 197, 98, 97};
    int bnd_idx [6] = '{0,   1,   0,   0,   11, 0};
    int bnd_val [6] = '{1,   1,   1,   0,   1,  0};

    initial begin
        // Reset state
        tick(3);
        check("rst_idx", 32'(note_idx), 0);
        check("rst_valid", 32'(note_valid), 0);
        check("rst_strobe", 32'(note_strobe), 0);
`ifdef NOTE_DET_PERIOD_OUT_EN
        check("rst_period", 32'(period_out), 0);
`endif
        reset = 1'b0;
        tick(2);

        // D#4 generator output: lock on the 4th rising edge
        s0 = strobe_cnt;
        drive_n(161, 4);
        check("dsharp_idx", 32'(note_idx), 3);
        check("dsharp_valid", 32'(note_valid), 1);
        check("dsharp_strobes", 32'(strobe_cnt - s0), 1);
`ifdef NOTE_DET_PERIOD_OUT_EN
        check("dsharp_period", 32'(period_out), 161);
`endif

        // A4 lock, then switch to C4. The first C4 rising edge still closes an
        // A4 period; the second closes the first C4 period and breaks the lock.
        do_reset();
        s0 = strobe_cnt;
        drive_n(114, 4);
        check("a4_idx", 32'(note_idx), 9);
        check("a4_valid", 32'(note_valid), 1);
        drive_period(191);
        check("a4_hold_valid", 32'(note_valid), 1);
        drive_period(191);
        check("c4_drop_valid", 32'(note_valid), 0);
        check("c4_drop_idx", 32'(note_idx), 9);
        drive_n(191, 2);
        check("c4_relock_idx", 32'(note_idx), 0);
        check("c4_relock_valid", 32'(note_valid), 1);
        check("a4c4_strobes", 32'(strobe_cnt - s0), 2);
`ifdef NOTE_DET_PERIOD_OUT_EN
        check("c4_period", 32'(period_out), 191);
`endif

        // Out-of-range period never locks
        do_reset();
        s0 = strobe_cnt;
        drive_n(250, 6);
        check("oor_valid", 32'(note_valid), 0);
        check("oor_idx", 32'(note_idx), 0);
        check("oor_strobes", 32'(strobe_cnt - s0), 0);
`ifdef NOTE_DET_PERIOD_OUT_EN
        check("oor_period", 32'(period_out), 250);
`endif

        // E4 lock then silence: drops about TIMEOUT cycles after the last edge
        do_reset();
        drive_n(152, 4);
        check("e4_valid", 32'(note_valid), 1);
        check("e4_idx", 32'(note_idx), 4);
        tick(240);
        check("e4_pre_timeout_valid", 32'(note_valid), 1);
        tick(20);
        check("e4_timeout_valid", 32'(note_valid), 0);
        check("e4_timeout_idx", 32'(note_idx), 4);

        // Reset while locked on G4, then relock
        do_reset();
        drive_n(128, 4);
        check("g4_valid", 32'(note_valid), 1);
        check("g4_idx", 32'(note_idx), 7);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("g4_rst_idx", 32'(note_idx), 0);
        check("g4_rst_valid", 32'(note_valid), 0);
        check("g4_rst_strobe", 32'(note_strobe), 0);
`ifdef NOTE_DET_PERIOD_OUT_EN
        check("g4_rst_period", 32'(period_out), 0);
`endif
        tick(2);
        reset = 1'b0;
        tick(2);
        drive_n(128, 4);
        check("g4_relock_idx", 32'(note_idx), 7);
        check("g4_relock_valid", 32'(note_valid), 1);

        // Band boundaries: midpoint goes to lower index, just outside extremes is no-match
        for (int b = 0; b < 6; b++) begin
            do_reset();
            drive_n(bnd_p[b], 4);
            check($sformatf("bnd_%0d_valid", bnd_p[b]), 32'(note_valid), 32'(bnd_val[b]));
            check($sformatf("bnd_%0d_idx", bnd_p[b]), 32'(note_idx), 32'(bnd_idx[b]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
